// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD command driver.
package lcd_pkg;

  // Command sequencer states; the driver exposes the current one for debug.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_t;

  // Field positions inside the 32-bit LCD register.
  localparam int ON_BIT   = 31;
  localparam int RS_BIT   = 9;
  localparam int RW_BIT   = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Instructions that need the long execution wait.
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Default timing, in clock cycles.
  localparam int DEF_SETUP     = 2;
  localparam int DEF_PULSE     = 12;
  localparam int DEF_HOLD      = 2;
  localparam int DEF_EXEC      = 2000;
  localparam int DEF_EXEC_LONG = 82000;

  // A zero cycle count cannot be timed; treat it as one cycle.
  function automatic int fix_zero(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Signal bundle between the register file / panel side and the LCD driver.
// There is no valid/ready pair: a command is requested simply by changing
// lcd_reg[9:0]; the driver samples it only while idle, so values written
// while busy are not queued and only the latest one is issued.
interface lcd_if;
  import lcd_pkg::*;

  logic [31:0] i_lcd_reg;
  logic [7:0]  i_lcd_din;
  logic        o_lcd_on;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic [7:0]  o_lcd_dout;
  logic        o_lcd_oe;
  logic        o_busy;
  logic [7:0]  o_rd_data;
  lcd_state_t  dbg_state;

  // Register file and panel side.
  modport master (
    output i_lcd_reg, i_lcd_din,
    input  o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_dout, o_lcd_oe,
    input  o_busy, o_rd_data, dbg_state
  );

  // Driver side.
  modport slave (
    input  i_lcd_reg, i_lcd_din,
    output o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_dout, o_lcd_oe,
    output o_busy, o_rd_data, dbg_state
  );

endinterface

// File: rtl/lcd_driver.sv
// HD44780-style LCD bus driver: turns changes of the LCD register into
// timed setup / enable-pulse / hold / execution-wait sequences.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int P_SETUP     = DEF_SETUP,
  parameter int P_PULSE     = DEF_PULSE,
  parameter int P_HOLD      = DEF_HOLD,
  parameter int P_EXEC      = DEF_EXEC,
  parameter int P_EXEC_LONG = DEF_EXEC_LONG
) (
  input logic  i_clk,
  input logic  i_rst,
  lcd_if.slave bus
);

  localparam int SETUP_N = fix_zero(P_SETUP);
  localparam int PULSE_N = fix_zero(P_PULSE);
  localparam int HOLD_N  = fix_zero(P_HOLD);
  localparam int EXEC_N  = fix_zero(P_EXEC);
  localparam int LONG_N  = fix_zero(P_EXEC_LONG);
  localparam int MAX_N   = max_int(max_int(max_int(SETUP_N, PULSE_N),
                                           max_int(HOLD_N, EXEC_N)), LONG_N);
  localparam int CW      = $clog2(MAX_N + 1);

  // Counter load values: each state lasts N cycles, exiting at count 0.
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_N - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_N - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_N - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(LONG_N - 1);

  lcd_state_t    state;
  logic [9:0]    shadow;
  logic [CW-1:0] cnt;
  logic          on_r;
  logic          rs_r;
  logic          rw_r;
  logic          en_r;
  logic [7:0]    dout_r;
  logic          oe_r;
  logic [7:0]    rd_r;
  logic          is_long;
  logic          unused_bits;

  // Clear and home take far longer to execute on the panel.
  assign is_long = !rs_r && ((dout_r == CMD_CLEAR) || (dout_r == CMD_HOME));

  // Bits of the register this block does not use.
  assign unused_bits = ^bus.i_lcd_reg[ON_BIT-1:RS_BIT+1];

  // Command sequencer: latches a new command in IDLE and walks the bus timing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      shadow <= '0;
      cnt    <= '0;
      on_r   <= 1'b0;
      rs_r   <= 1'b0;
      rw_r   <= 1'b0;
      en_r   <= 1'b0;
      dout_r <= '0;
      oe_r   <= 1'b0;
      rd_r   <= '0;
    end else begin
      on_r <= bus.i_lcd_reg[ON_BIT];
      case (state)
        ST_IDLE: begin
          if (bus.i_lcd_reg[RS_BIT:0] != shadow) begin
            shadow <= bus.i_lcd_reg[RS_BIT:0];
            rs_r   <= bus.i_lcd_reg[RS_BIT];
            rw_r   <= bus.i_lcd_reg[RW_BIT];
            dout_r <= bus.i_lcd_reg[DATA_MSB:DATA_LSB];
            oe_r   <= ~bus.i_lcd_reg[RW_BIT];
            cnt    <= LD_SETUP;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            en_r  <= 1'b1;
            cnt   <= LD_PULSE;
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            if (rw_r) begin
              rd_r <= bus.i_lcd_din;
            end
            en_r  <= 1'b0;
            cnt   <= LD_HOLD;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long ? LD_LONG : LD_EXEC;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            oe_r  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          en_r  <= 1'b0;
          oe_r  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_lcd_on   = on_r;
  assign bus.o_lcd_rs   = rs_r;
  assign bus.o_lcd_rw   = rw_r;
  assign bus.o_lcd_en   = en_r;
  assign bus.o_lcd_dout = dout_r;
  assign bus.o_lcd_oe   = oe_r;
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_rd_data  = rd_r;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with short timing parameters.
module tb_lcd_driver;
  import lcd_pkg::*;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 8;
  localparam int T_LONG  = 20;

  logic i_clk;
  logic i_rst;
  lcd_if bus ();

  lcd_driver #(
    .P_SETUP    (T_SETUP),
    .P_PULSE    (T_PULSE),
    .P_HOLD     (T_HOLD),
    .P_EXEC     (T_EXEC),
    .P_EXEC_LONG(T_LONG)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic       en_q = 1'b0;

  // Log {rs, rw, dout} at every rising edge of E.
  always @(negedge i_clk) begin
    en_q <= bus.o_lcd_en;
    if (bus.o_lcd_en && !en_q) obs_q.push_back({bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_dout});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_val($sformatf("%s_pulse%0d", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int   r_busy, r_setup, r_pulse, r_tail;
  logic r_rs, r_rw, r_oe, r_on, r_stable, r_done;
  logic [7:0] r_dout;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Apply a register value and profile the resulting command cycle by cycle.
  // The panel only presents din_val during the last E-high cycle.
  task automatic run_cmd(input logic [31:0] val, input logic [7:0] din_val);
    r_busy = 0; r_setup = 0; r_pulse = 0; r_tail = 0;
    r_stable = 1'b1; r_done = 1'b0;
    bus.i_lcd_din = 8'hA5;
    bus.i_lcd_reg = val;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (!bus.o_busy) begin
        r_done = 1'b1;
        break;
      end
      if (c == 0) begin
        r_rs = bus.o_lcd_rs; r_rw = bus.o_lcd_rw; r_dout = bus.o_lcd_dout;
        r_oe = bus.o_lcd_oe; r_on = bus.o_lcd_on;
      end
      if ({bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_dout} != {r_rs, r_rw, r_dout}) r_stable = 1'b0;
      r_busy++;
      if (bus.o_lcd_en) r_pulse++;
      else if (r_pulse == 0) r_setup++;
      else r_tail++;
      bus.i_lcd_din = (bus.o_lcd_en && r_pulse == T_PULSE) ? din_val : 8'hA5;
    end
    bus.i_lcd_din = 8'hA5;
    check_val("cmd_finished", r_done, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int en_seen, busy_seen;

  initial begin
    i_rst = 1'b1;
    bus.i_lcd_reg = '0;
    bus.i_lcd_din = 8'hA5;
    repeat (3) tick();

    // Reset state.
    check_val("rst_busy", bus.o_busy, 0);
    check_val("rst_state", bus.dbg_state, ST_IDLE);
    check_val("rst_outs", {bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_en, bus.o_lcd_oe}, 0);
    check_val("rst_dout", bus.o_lcd_dout, 0);
    check_val("rst_rd_data", bus.o_rd_data, 0);

    // Zero register after reset issues nothing.
    i_rst = 1'b0;
    repeat (6) tick();
    check_val("idle_after_rst", bus.o_busy, 0);
    check_log("zero_reg");

    // Normal write.
    run_cmd(32'h8000_0041, 8'h00);
    exp_q.push_back(10'h041);
    check_val("wr_first", {r_rs, r_rw, r_oe, r_on}, 4'b0011);
    check_val("wr_dout", r_dout, 8'h41);
    check_val("wr_setup", r_setup, 2);
    check_val("wr_pulse", r_pulse, 4);
    check_val("wr_tail", r_tail, 10);
    check_val("wr_busy", r_busy, 16);
    check_val("wr_stable", r_stable, 1);
    check_val("wr_oe_idle", bus.o_lcd_oe, 0);
    check_log("wr");

    // Clear and home take the long wait.
    run_cmd(32'h0000_0001, 8'h00);
    exp_q.push_back(10'h001);
    check_val("clr_tail", r_tail, 22);
    check_val("clr_busy", r_busy, 28);
    check_val("clr_on", bus.o_lcd_on, 0);
    run_cmd(32'h0000_0002, 8'h00);
    exp_q.push_back(10'h002);
    check_val("home_busy", r_busy, 28);
    // Data write of 0x01 (RS=1) is a normal command.
    run_cmd(32'h0000_0201, 8'h00);
    exp_q.push_back(10'h201);
    check_val("data01_busy", r_busy, 16);
    check_log("long");

    // Read captures din on the last E-high cycle.
    run_cmd(32'h0000_0300, 8'h5A);
    exp_q.push_back(10'h300);
    check_val("rd_first", {r_rs, r_rw, r_oe}, 3'b110);
    check_val("rd_pulse", r_pulse, 4);
    check_val("rd_data", bus.o_rd_data, 8'h5A);
    // A write leaves the captured byte alone.
    run_cmd(32'h0000_00A5, 8'h33);
    exp_q.push_back(10'h0A5);
    check_val("rd_data_kept", bus.o_rd_data, 8'h5A);
    check_log("rd");

    // Overwrite while busy: only the newest value follows.
    bus.i_lcd_reg = 32'h0000_0041;
    tick(); tick(); tick();
    check_val("ow_in_pulse", bus.o_lcd_en, 1);
    bus.i_lcd_reg = 32'h0000_0042;
    tick();
    bus.i_lcd_reg = 32'h0000_0043;
    repeat (60) tick();
    check_val("ow_idle", bus.o_busy, 0);
    exp_q.push_back(10'h041);
    exp_q.push_back(10'h043);
    check_log("ow");

    // Same value again and toggling ON only: no command.
    bus.i_lcd_reg = 32'h8000_0043;
    check_val("on_latency0", bus.o_lcd_on, 0);
    en_seen = 0; busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) check_val("on_latency1", bus.o_lcd_on, 1);
      if (bus.o_lcd_en) en_seen++;
      if (bus.o_busy) busy_seen++;
    end
    bus.i_lcd_reg = 32'h0000_0043;
    tick();
    check_val("on_off", bus.o_lcd_on, 0);
    check_val("same_no_en", en_seen, 0);
    check_val("same_no_busy", busy_seen, 0);
    check_log("same");

    // Reset in the middle of the E pulse.
    bus.i_lcd_reg = 32'h8000_0055;
    tick(); tick(); tick();
    check_val("rstmid_en", bus.o_lcd_en, 1);
    exp_q.push_back(10'h055);
    i_rst = 1'b1;
    bus.i_lcd_reg = '0;
    tick();
    check_val("rstmid_en0", bus.o_lcd_en, 0);
    check_val("rstmid_outs", {bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_oe, bus.o_busy}, 0);
    check_val("rstmid_dout", bus.o_lcd_dout, 0);
    check_val("rstmid_rd", bus.o_rd_data, 0);
    i_rst = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.o_busy) busy_seen++;
    end
    check_val("rstmid_no_reissue", busy_seen, 0);
    check_log("rstmid");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lcd_driver.md
LCD_DRIVER -- requirements
Module: lcd_driver

Interface
REQ-001 SHALL have parameter P_SETUP, default 2, meaning cycles RS/RW/DATA are stable before E rises.
REQ-002 SHALL have parameter P_PULSE, default 12, meaning cycles E is held high.
REQ-003 SHALL have parameter P_HOLD, default 2, meaning cycles RS/RW/DATA are held after E falls.
REQ-004 SHALL have parameter P_EXEC, default 2000, meaning post-command wait cycles for a normal command.
REQ-005 SHALL have parameter P_EXEC_LONG, default 82000, meaning post-command wait cycles for clear (0x01) or home (0x02) with RS=0.
REQ-006 i_clk  in  1  clock; all logic on rising edge.
REQ-007 i_rst  in  1  reset, synchronous, active-high.
REQ-008 i_lcd_reg  in  32  LCD register from the LSU output buffer; [31]=ON, [9]=RS, [8]=RW, [7:0]=DATA; other bits ignored.
REQ-009 i_lcd_din  in  8  data bus from the panel, sampled on reads.
REQ-010 o_lcd_on  out  1  panel power/backlight.
REQ-011 o_lcd_rs  out  1  register select.
REQ-012 o_lcd_rw  out  1  1=read, 0=write.
REQ-013 o_lcd_en  out  1  enable strobe E.
REQ-014 o_lcd_dout  out  8  write data to the panel.
REQ-015 o_lcd_oe  out  1  drives o_lcd_dout onto the bus when 1; equals ~RW during an active command, 0 in IDLE.
REQ-016 o_busy  out  1  1 whenever state != IDLE.
REQ-017 o_rd_data  out  8  last byte captured by a read command.

Function
REQ-018 SHALL implement states IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-019 SHALL keep a 10-bit shadow of the last accepted i_lcd_reg[9:0].
REQ-020 In IDLE, when i_lcd_reg[9:0] != shadow, SHALL load shadow, RS, RW, and DOUT at the next edge and enter SETUP.
REQ-021 Otherwise SHALL remain in IDLE.
REQ-022 SETUP SHALL last exactly P_SETUP cycles with E=0, then enter PULSE.
REQ-023 PULSE SHALL last exactly P_PULSE cycles with E=1, then enter HOLD.
REQ-024 HOLD SHALL last exactly P_HOLD cycles with E=0, then enter WAIT.
REQ-025 WAIT SHALL last P_EXEC_LONG cycles if the latched RS=0 and DATA is 0x01 or 0x02, else P_EXEC cycles, then enter IDLE.
REQ-026 A single down-counter of width clog2(max parameter + 1) SHALL time all states; it is loaded with (N-1) on entry, and the state exits at count 0.
REQ-027 For RW=1, SHALL capture i_lcd_din into o_rd_data on the last PULSE cycle; o_rd_data SHALL be unchanged otherwise.
REQ-028 i_lcd_reg changes while busy SHALL NOT be queued; on return to IDLE the current value is compared again, so only the latest value is issued and intermediate values are dropped.
REQ-029 A change that returns to the shadow value while busy SHALL issue nothing.
REQ-030 o_lcd_on SHALL follow i_lcd_reg[31] with one-cycle latency, independent of state.
REQ-031 RS, RW, and DOUT SHALL remain constant from SETUP entry through WAIT exit.
REQ-032 A parameter value of 0 is illegal and is treated as 1.

Reset
REQ-033 On i_rst, SHALL enter IDLE and clear the shadow, counter, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_dout, o_lcd_oe, and o_rd_data.
REQ-034 Reset mid-command SHALL drop E to 0 at the next edge and abort the command without completing it.
REQ-035 After reset, i_lcd_reg[9:0]=0 SHALL issue no command.

Structure
REQ-036 Package lcd_pkg SHALL hold the state enum, field bit positions (ON=31, RS=9, RW=8, DATA=7:0), CMD_CLEAR=0x01, CMD_HOME=0x02, and the default timing constants.
REQ-037 SHALL be a single module with no sub-module; the counter is inline.

Verification (P_SETUP=2, P_PULSE=4, P_HOLD=2, P_EXEC=8, P_EXEC_LONG=20)
REQ-038 Write: i_lcd_reg=0x8000_0041 -> one edge later rs=0, rw=0, dout=0x41, oe=1, on=1; E high for exactly 4 cycles after 2 setup cycles; busy for 2+4+2+8=16 cycles.
REQ-039 Clear: i_lcd_reg=0x0000_0001 -> WAIT lasts 20 cycles; total busy 28 cycles.
REQ-040 Read: i_lcd_reg=0x0000_0300 with i_lcd_din=0x5A -> rw=1, oe=0; o_rd_data=0x5A after PULSE.
REQ-041 Overwrite while busy: write 0x041, then 0x042 and 0x043 during PULSE -> exactly two commands (0x41, then 0x43); 0x42 is never driven.
REQ-042 Reset during PULSE -> E=0 at the next edge, all outputs 0, and no command reissued while i_lcd_reg=0.
REQ-043 Unchanged value: rewrite the same i_lcd_reg value after completion -> no new E pulse; toggling only bit 31 changes o_lcd_on and nothing else.
